// File: rtl/ram_arbiter.sv
// Purpose: shares one RAM port between requester A and requester B using round-robin, and routes each read response back to the port that issued the read.
// Latency: a granted command appears on mem_* 1 cycle later; a read response reaches the issuing port 1 cycle after mem_data_read_valid.
// Backpressure: X_ready is the same-cycle grant; reads stall only while MAX_OUTST reads are in flight and no response pops this cycle.

module ram_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_wr_en,
    input  logic              a_rd_en,
    input  logic [DATA_W-1:0] a_data_write,
    output logic              a_ready,
    output logic [DATA_W-1:0] a_data_read,
    output logic              a_data_read_valid,

    input  logic [ADDR_W-1:0] b_addr,
    input  logic              b_wr_en,
    input  logic              b_rd_en,
    input  logic [DATA_W-1:0] b_data_write,
    output logic              b_ready,
    output logic [DATA_W-1:0] b_data_read,
    output logic              b_data_read_valid,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic              mem_rd_en,
    output logic [DATA_W-1:0] mem_data_write,
    input  logic [DATA_W-1:0] mem_data_read,
    input  logic              mem_data_read_valid,

    output logic              err_both
);

    // Pointer width is kept at least 1 bit so a depth-1 FIFO still elaborates.
    localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CW = $clog2(MAX_OUTST + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTST);
    localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTST - 1);

    // Round-robin pointer: names the port that wins the next two-way contention.
    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    port_t rr_ptr;
    port_t rr_next;

    // Request decode. A port driving wr_en and rd_en together is treated as a write.
    logic a_req;
    logic a_is_wr;
    logic a_is_rd;
    logic b_req;
    logic b_is_wr;
    logic b_is_rd;

    // Tag FIFO state. Each entry holds the id of the port that issued an outstanding read (1 = B).
    logic [MAX_OUTST-1:0] tag_mem;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        fifo_count;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 push_tag;
    logic                 head_is_b;

    // Arbitration.
    logic rd_room;
    logic a_elig;
    logic b_elig;
    logic grant_a;
    logic grant_b;

    // Classify each port's request; a simultaneous read is dropped in favour of the write.
    always_comb begin
        a_req   = a_wr_en | a_rd_en;
        a_is_wr = a_wr_en;
        a_is_rd = a_rd_en & ~a_wr_en;
        b_req   = b_wr_en | b_rd_en;
        b_is_wr = b_wr_en;
        b_is_rd = b_rd_en & ~b_wr_en;
    end

    // Pop the tag FIFO on a response only when something is outstanding; stray strobes are ignored.
    always_comb begin
        fifo_empty = (fifo_count == '0);
        pop        = mem_data_read_valid & ~fifo_empty;
        head_is_b  = tag_mem[rd_ptr];
    end

    // Eligibility and grant. A read may take the slot freed by a pop in the same cycle.
    always_comb begin
        rd_room = (fifo_count < FULL_CNT) | pop;
        a_elig  = a_req & (a_is_wr | rd_room);
        b_elig  = b_req & (b_is_wr | rd_room);
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (reset) begin
            if (a_elig && (!b_elig || rr_ptr == PORT_A)) begin
                grant_a = 1'b1;
            end else if (b_elig) begin
                grant_b = 1'b1;
            end
        end
    end

    // Ready is the grant itself, so acceptance is simply ready at the clock edge.
    always_comb begin
        a_ready  = grant_a;
        b_ready  = grant_b;
        push     = (grant_a & a_is_rd) | (grant_b & b_is_rd);
        push_tag = grant_b;
    end

    // Round-robin state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr <= PORT_A;
        end else begin
            rr_ptr <= rr_next;
        end
    end

    // Round-robin next state: after any grant, favour the port that lost.
    always_comb begin
        rr_next = rr_ptr;
        if (grant_a) begin
            rr_next = PORT_B;
        end else if (grant_b) begin
            rr_next = PORT_A;
        end
    end

    // Register the winning command onto the RAM bus; enables pulse for one cycle, addr/data hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_wr_en      <= 1'b0;
            mem_rd_en      <= 1'b0;
            mem_addr       <= '0;
            mem_data_write <= '0;
        end else begin
            mem_wr_en <= (grant_a & a_is_wr) | (grant_b & b_is_wr);
            mem_rd_en <= push;
            if (grant_a) begin
                mem_addr       <= a_addr;
                mem_data_write <= a_data_write;
            end else if (grant_b) begin
                mem_addr       <= b_addr;
                mem_data_write <= b_data_write;
            end
        end
    end

    // Tag storage; entries are only read behind a valid count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr] <= push_tag;
        end
    end

    // Tag FIFO pointers and occupancy; reset empties it so late responses are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Steer each popped response to the port named by the FIFO head; read data holds between strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_data_read_valid <= 1'b0;
            b_data_read_valid <= 1'b0;
            a_data_read       <= '0;
            b_data_read       <= '0;
        end else begin
            a_data_read_valid <= pop & ~head_is_b;
            b_data_read_valid <= pop & head_is_b;
            if (pop && !head_is_b) begin
                a_data_read <= mem_data_read;
            end
            if (pop && head_is_b) begin
                b_data_read <= mem_data_read;
            end
        end
    end

    // Sticky flag for a port driving wr_en and rd_en together; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_both <= 1'b0;
        end else if ((a_wr_en && a_rd_en) || (b_wr_en && b_rd_en)) begin
            err_both <= 1'b1;
        end
    end

endmodule
